// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for mem_port_arbiter
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_LSU   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  we;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - response watchdog counter for mem_port_arbiter
module mem_arb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled enable cannot wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and LSU
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  input  logic              i_req0_we,
  output logic              o_req0_ready,
  output logic              o_rsp0_valid,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  input  logic              i_req1_we,
  output logic              o_req1_ready,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  input  logic              i_mem_rsp_valid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_sel,
  output logic              o_busy
);

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic              sel_q, sel_d;
  logic              rr_last_q, rr_last_d;
  logic              mem_valid_q, mem_valid_d;
  logic              busy_q, busy_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic idle_ok, grant0, grant1;
  logic tmo_clr, tmo_en, tmo_expired;

  // On contention the port that did not win last time is granted.
  assign idle_ok = (state_q == IDLE) && !i_reset;
  assign grant0  = idle_ok && i_req0_valid && (!i_req1_valid || (rr_last_q == SEL_LSU));
  assign grant1  = idle_ok && i_req1_valid && (!i_req0_valid || (rr_last_q == SEL_FETCH));

  assign tmo_clr = (state_q == ISSUE) && i_mem_ready;
  assign tmo_en  = (state_q == WAIT_RSP);

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (tmo_clr),
    .i_en      (tmo_en),
    .o_expired (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    rsp0_d    = 1'b0;
    rsp1_d    = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          sel_d       = grant1 ? SEL_LSU : SEL_FETCH;
          rr_last_d   = sel_d;
          req_d.addr  = MEM_ADDR_W'(grant1 ? i_req1_addr : i_req0_addr);
          req_d.wdata = MEM_DATA_W'(grant1 ? i_req1_wdata : i_req0_wdata);
          req_d.we    = grant1 ? i_req1_we : i_req0_we;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (i_mem_rsp_valid) begin
          rsp0_d  = (sel_q == SEL_FETCH);
          rsp1_d  = (sel_q == SEL_LSU);
          rdata_d = i_mem_rdata;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (tmo_expired) begin
          rsp0_d  = (sel_q == SEL_FETCH);
          rsp1_d  = (sel_q == SEL_LSU);
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      sel_q       <= SEL_FETCH;
      rr_last_q   <= SEL_LSU;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      mem_valid_q <= mem_valid_d;
      busy_q      <= busy_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign o_rsp0_valid = rsp0_q;
  assign o_rsp1_valid = rsp1_q;
  assign o_rsp_rdata  = rdata_q;
  assign o_rsp_err    = err_q;
  assign o_mem_valid  = mem_valid_q;
  assign o_mem_addr   = ADDR_W'(req_q.addr);
  assign o_mem_wdata  = DATA_W'(req_q.wdata);
  assign o_mem_we     = req_q.we;
  assign o_sel        = sel_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        i_clk;
  logic        i_reset;
  logic        i_req0_valid, i_req0_we, o_req0_ready, o_rsp0_valid;
  logic [31:0] i_req0_addr, i_req0_wdata;
  logic        i_req1_valid, i_req1_we, o_req1_ready, o_rsp1_valid;
  logic [31:0] i_req1_addr, i_req1_wdata;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic        o_rsp_err, o_mem_valid, o_mem_we, i_mem_ready, i_mem_rsp_valid;
  logic        o_sel, o_busy;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_req0_valid    (i_req0_valid),
    .i_req0_addr     (i_req0_addr),
    .i_req0_wdata    (i_req0_wdata),
    .i_req0_we       (i_req0_we),
    .o_req0_ready    (o_req0_ready),
    .o_rsp0_valid    (o_rsp0_valid),
    .i_req1_valid    (i_req1_valid),
    .i_req1_addr     (i_req1_addr),
    .i_req1_wdata    (i_req1_wdata),
    .i_req1_we       (i_req1_we),
    .o_req1_ready    (o_req1_ready),
    .o_rsp1_valid    (o_rsp1_valid),
    .o_rsp_rdata     (o_rsp_rdata),
    .o_rsp_err       (o_rsp_err),
    .o_mem_valid     (o_mem_valid),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_we        (o_mem_we),
    .i_mem_ready     (i_mem_ready),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rdata     (i_mem_rdata),
    .o_sel           (o_sel),
    .o_busy          (o_busy)
  );

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } grant_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          chk;
    logic        err;
    int          lat;
  } rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  grant_t cur;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     grant_cyc = 0;
  bit     hang = 0;
  bit     done = 0;
  logic   rst_q = 1'b0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end (got timeout, want finish)");
    $fatal(1);
  end

  always @(posedge i_clk) rst_q <= i_reset;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_txn(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [31:0] rdata, input bit chk,
                         input logic err, input int lat);
    grant_t g;
    rsp_t   r;
    g.port = port; g.addr = addr; g.wdata = wdata; g.we = we;
    r.port = port; r.rdata = rdata; r.chk = chk; r.err = err; r.lat = lat;
    gq.push_back(g);
    rq.push_back(r);
  endtask

  // Monitor: response before grant so a same-cycle regrant does not disturb the latency check.
  initial begin
    cur = '{port: 1'b0, addr: 32'h0, wdata: 32'h0, we: 1'b0};
    forever begin
      @(negedge i_clk);
      cyc++;
      if (rst_q) begin
        check("reset_outputs",
              {o_rsp0_valid, o_rsp1_valid, o_rsp_err, o_mem_valid, o_mem_we, o_sel, o_busy,
               |o_rsp_rdata, |o_mem_addr, |o_mem_wdata}, 64'h0);
      end
      if (i_reset) begin
        check("reset_ready", {o_req0_ready, o_req1_ready}, 64'h0);
      end else begin
        if (o_busy) check("ready_while_busy", {o_req0_ready, o_req1_ready}, 64'h0);
        if (o_rsp0_valid || o_rsp1_valid) begin
          if (rq.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            rsp_t r;
            r = rq.pop_front();
            check("rsp_port", {o_rsp1_valid, o_rsp0_valid}, r.port ? 64'h2 : 64'h1);
            check("rsp_err", o_rsp_err, r.err);
            if (r.chk) check("rsp_rdata", o_rsp_rdata, r.rdata);
            check("rsp_latency", cyc - grant_cyc, r.lat);
          end
        end
        if (o_req0_ready || o_req1_ready) begin
          if (gq.size() == 0) begin
            check("grant_unexpected", 1, 0);
          end else begin
            cur = gq.pop_front();
            check("grant_port", {o_req1_ready, o_req0_ready}, cur.port ? 64'h2 : 64'h1);
            grant_cyc = cyc;
          end
        end
        if (o_mem_valid) begin
          check("mem_addr", o_mem_addr, cur.addr);
          check("mem_wdata", o_mem_wdata, cur.wdata);
          check("mem_we_sel", {o_mem_we, o_sel}, {cur.we, cur.port});
        end
      end
      if (done) begin
        check("grants_left", gq.size(), 0);
        check("rsps_left", rq.size(), 0);
        check("stim_hang", hang, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic request(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we);
    int n;
    if (port) begin
      i_req1_addr = addr; i_req1_wdata = wdata; i_req1_we = we; i_req1_valid = 1'b1;
    end else begin
      i_req0_addr = addr; i_req0_wdata = wdata; i_req0_we = we; i_req0_valid = 1'b1;
    end
    n = 0;
    @(negedge i_clk);
    while (!(port ? o_req1_ready : o_req0_ready) && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    if (!(port ? o_req1_ready : o_req0_ready)) hang = 1'b1;
    tick();
    if (port) i_req1_valid = 1'b0;
    else      i_req0_valid = 1'b0;
  endtask

  task automatic serve(input int rdy_wait, input int rsp_wait, input bit do_rsp,
                       input logic [31:0] rd);
    int n;
    n = 0;
    while (!o_mem_valid && n < 40) begin
      tick();
      n++;
    end
    if (!o_mem_valid) hang = 1'b1;
    repeat (rdy_wait) tick();
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0;
    if (do_rsp) begin
      repeat (rsp_wait) tick();
      i_mem_rsp_valid = 1'b1;
      i_mem_rdata = rd;
      tick();
      i_mem_rsp_valid = 1'b0;
    end else begin
      repeat (TMO) tick();
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_req0_valid = 1'b0; i_req0_addr = '0; i_req0_wdata = '0; i_req0_we = 1'b0;
    i_req1_valid = 1'b0; i_req1_addr = '0; i_req1_wdata = '0; i_req1_we = 1'b0;
    i_mem_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rdata = '0;

    // Reset with both ports requesting, then continuous contention: 0,1,0,1.
    exp_txn(1'b0, 32'h40,  32'h0,         1'b0, 32'h1111_0000, 1'b1, 1'b0, 3);
    exp_txn(1'b1, 32'h100, 32'h1234_5678, 1'b1, 32'h0,         1'b0, 1'b0, 3);
    exp_txn(1'b0, 32'h40,  32'h0,         1'b0, 32'h3333_0000, 1'b1, 1'b0, 3);
    exp_txn(1'b1, 32'h100, 32'h1234_5678, 1'b1, 32'h0,         1'b0, 1'b0, 3);
    i_req0_valid = 1'b1; i_req0_addr = 32'h40;
    i_req1_valid = 1'b1; i_req1_addr = 32'h100; i_req1_wdata = 32'h1234_5678; i_req1_we = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    serve(0, 0, 1'b1, 32'h1111_0000);
    serve(0, 0, 1'b1, 32'hFFFF_FFFF);
    serve(0, 0, 1'b1, 32'h3333_0000);
    serve(0, 0, 1'b1, 32'hFFFF_FFFF);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_req1_we = 1'b0;
    repeat (2) tick();

    // Single read on port 0.
    exp_txn(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3);
    request(1'b0, 32'h10, 32'h0, 1'b0);
    serve(0, 0, 1'b1, 32'hDEAD_BEEF);
    repeat (2) tick();

    // Backpressure: port 0 asks while busy, then withdraws before being served.
    exp_txn(1'b1, 32'h200, 32'hABCD_0123, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, 8);
    request(1'b1, 32'h200, 32'hABCD_0123, 1'b0);
    i_req0_addr = 32'h300; i_req0_valid = 1'b1;
    serve(5, 0, 1'b1, 32'h0BAD_F00D);
    i_req0_valid = 1'b0;
    repeat (2) tick();

    // Timeout with no response, then a response in the expiry cycle.
    exp_txn(1'b1, 32'h400, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 6);
    request(1'b1, 32'h400, 32'h0, 1'b0);
    serve(0, 0, 1'b0, 32'h0);
    repeat (2) tick();
    exp_txn(1'b0, 32'h500, 32'h0, 1'b0, 32'h5555_AAAA, 1'b1, 1'b0, 6);
    request(1'b0, 32'h500, 32'h0, 1'b0);
    serve(0, 3, 1'b1, 32'h5555_AAAA);
    repeat (2) tick();

    // Reset during WAIT_RSP, then a late response that must be dropped.
    begin
      grant_t g;
      g.port = 1'b1; g.addr = 32'h600; g.wdata = 32'hCAFE_F00D; g.we = 1'b1;
      gq.push_back(g);
    end
    request(1'b1, 32'h600, 32'hCAFE_F00D, 1'b1);
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'h9999_9999;
    repeat (2) tick();
    i_mem_rsp_valid = 1'b0;
    repeat (2) tick();

    // After reset the round-robin pointer favours port 0 again.
    exp_txn(1'b0, 32'h700, 32'h0, 1'b0, 32'h7777_7777, 1'b1, 1'b0, 3);
    i_req0_addr = 32'h700; i_req0_wdata = 32'h0; i_req0_we = 1'b0; i_req0_valid = 1'b1;
    i_req1_addr = 32'h800; i_req1_wdata = 32'h8888_0000; i_req1_we = 1'b1; i_req1_valid = 1'b1;
    serve(0, 0, 1'b1, 32'h7777_7777);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    repeat (3) tick();
    done = 1'b1;
  end

endmodule
